// File: rtl/rv32_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_dmem_responder_if
// Description : Data-memory bus between the RV32 core (master) and the
//               memory/timer responder (slave).
//               address     - byte address, bits [1:0] ignored
//               write       - single-cycle write strobe
//               writedata   - write data
//               byteenable  - byte lanes for writes
//               read        - read request, held until waitrequest is low
//               readdata    - read data, valid when read=1 and waitrequest=0
//               waitrequest - read stall, never asserted for writes
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_dmem_responder_if;
   logic [31:0] address;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        read;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address, write, writedata, byteenable, read,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, write, writedata, byteenable, read,
      output readdata, waitrequest
   );
endinterface
`default_nettype wire

// File: rtl/rv32_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : rv32_dmem_responder
// Description : Responder on the core's data bus. Holds a word-addressed RAM
//               with byte-enabled writes and a fixed number of read wait
//               states, and turns full-word writes into a 16-byte timer
//               window into one-cycle mtime/mtimecmp update pulses.
// Ports       : clk            - clock
//               reset_n        - asynchronous active-low reset
//               bus            - data bus, slave side
//               wr_mtime       - one-cycle pulse: write an mtime word
//               wr_mtimecmp    - one-cycle pulse: write an mtimecmp word
//               wr_mtime_upper - qualifies the pulse: 1 = upper 32 bits
//               wr_mtime_val   - value for the pulsed timer word
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_dmem_responder #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
   parameter int          READ_WAIT  = 1,
   parameter logic [31:0] TIMER_BASE = 32'hAFFF_FFE0
) (
   input  wire logic               clk,
   input  wire logic               reset_n,
   rv32_dmem_responder_if.slave    bus,
   output      logic               wr_mtime,
   output      logic               wr_mtimecmp,
   output      logic               wr_mtime_upper,
   output      logic [31:0]        wr_mtime_val
);

   localparam int         c_depth     = 1 << ADDR_WIDTH;
   localparam logic [3:0] c_last_wait = 4'(READ_WAIT - 1);

   logic [31:0]           r_mem [0:c_depth-1];
   logic [3:0]            r_cnt;
   logic                  r_ready;
   logic [31:0]           r_readdata;
   logic                  r_wr_mtime;
   logic                  r_wr_mtimecmp;
   logic                  r_wr_upper;
   logic [31:0]           r_wr_val;

   logic                  w_ram_hit;
   logic                  w_timer_hit;
   logic                  w_timer_wr;
   logic [ADDR_WIDTH-1:0] w_word_idx;
   logic [3:0]            w_lane_we;
   logic                  w_unused;

   // ------------------------------------------------------------------------
   // Address decode. RAM is aligned to its own size, so a hit is a compare of
   // the bits above the word index.
   // ------------------------------------------------------------------------
   assign w_ram_hit   = (bus.address[31:ADDR_WIDTH+2] == RAM_BASE[31:ADDR_WIDTH+2]);
   assign w_timer_hit = (bus.address[31:4] == TIMER_BASE[31:4]);
   assign w_word_idx  = bus.address[ADDR_WIDTH+1:2];
   // Only full-word timer writes update the timer; partial writes are dropped.
   assign w_timer_wr  = bus.write & w_timer_hit & (bus.byteenable == 4'hF);
   assign w_unused    = &{1'b0, bus.address[1:0]};

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign w_lane_we[i] = bus.write & w_ram_hit & bus.byteenable[i];
   end

   // ------------------------------------------------------------------------
   // RAM storage (not reset).
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_lane_we[i]) begin
            r_mem[w_word_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read wait-state sequencing. The counter runs while the read is stalled;
   // ready rises the cycle after the last wait cycle, so waitrequest is high
   // for exactly READ_WAIT cycles. Completion (read & ready) or a dropped
   // read clears both, so a back-to-back read pays the full wait again.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= 4'd0;
         r_ready <= 1'b0;
      end else if (bus.read && !r_ready) begin
         if (r_cnt == c_last_wait) begin
            r_ready <= 1'b1;
         end
         r_cnt <= r_cnt + 4'd1;
      end else begin
         r_cnt   <= 4'd0;
         r_ready <= 1'b0;
      end
   end

   // Sampled on every read cycle; the value presented on completion was
   // captured on the previous edge, so a write to the same word in the
   // same cycle as that capture is seen by later captures only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= 32'h0;
      end else if (bus.read) begin
         r_readdata <= w_ram_hit ? r_mem[w_word_idx] : 32'h0;
      end
   end

   assign bus.waitrequest = bus.read & ~r_ready;
   assign bus.readdata    = r_readdata;

   // ------------------------------------------------------------------------
   // Timer window: offset bit 3 selects mtimecmp, bit 2 selects upper word.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_mtime    <= 1'b0;
         r_wr_mtimecmp <= 1'b0;
         r_wr_upper    <= 1'b0;
         r_wr_val      <= 32'h0;
      end else begin
         r_wr_mtime    <= w_timer_wr & ~bus.address[3];
         r_wr_mtimecmp <= w_timer_wr &  bus.address[3];
         r_wr_upper    <= w_timer_wr &  bus.address[2];
         if (w_timer_wr) begin
            r_wr_val <= bus.writedata;
         end
      end
   end

   assign wr_mtime       = r_wr_mtime;
   assign wr_mtimecmp    = r_wr_mtimecmp;
   assign wr_mtime_upper = r_wr_upper;
   assign wr_mtime_val   = r_wr_val;

endmodule
`default_nettype wire

// File: tb/tb_rv32_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_dmem_responder
// Description : Self-checking bench for rv32_dmem_responder. Two instances
//               (READ_WAIT=3 and READ_WAIT=1) share one set of bus inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_dmem_responder;

   localparam logic [31:0] c_tbase = 32'hAFFF_FFE0;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic [31:0] address    = 32'h0;
   logic        write      = 1'b0;
   logic [31:0] writedata  = 32'h0;
   logic [3:0]  byteenable = 4'h0;
   logic        read       = 1'b0;

   always #5 clk = ~clk;

   rv32_dmem_responder_if bus3 ();
   rv32_dmem_responder_if bus1 ();

   assign bus3.address = address;  assign bus1.address = address;
   assign bus3.write = write;      assign bus1.write = write;
   assign bus3.writedata = writedata;   assign bus1.writedata = writedata;
   assign bus3.byteenable = byteenable; assign bus1.byteenable = byteenable;
   assign bus3.read = read;        assign bus1.read = read;

   logic        wm3, wc3, wu3, wm1, wc1, wu1;
   logic [31:0] wv3, wv1;

   rv32_dmem_responder #(.ADDR_WIDTH(6), .RAM_BASE(32'h0), .READ_WAIT(3), .TIMER_BASE(c_tbase)) dut3 (
      .clk(clk), .reset_n(reset_n), .bus(bus3),
      .wr_mtime(wm3), .wr_mtimecmp(wc3), .wr_mtime_upper(wu3), .wr_mtime_val(wv3));

   rv32_dmem_responder #(.ADDR_WIDTH(6), .RAM_BASE(32'h0), .READ_WAIT(1), .TIMER_BASE(c_tbase)) dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1),
      .wr_mtime(wm1), .wr_mtimecmp(wc1), .wr_mtime_upper(wu1), .wr_mtime_val(wv1));

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [31:0] mem_m [0:63];
   logic [31:0] val_m = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: RAM is bytes 0..255, timer is c_tbase..c_tbase+15.
   function automatic logic [2:0] model_pulse(input logic [31:0] a, input logic [3:0] be);
      logic [31:0] off;
      off = a - c_tbase;
      if (off < 32'd16 && be == 4'hF) return {off < 32'd8, off >= 32'd8, off[2]};
      return 3'b000;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a < 32'd256) return mem_m[a[7:2]];
      return 32'h0;
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic [2:0] exp_pulse, input string name);
      @(negedge clk);
      address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
      #1 check({name, " waitrequest"}, {31'b0, bus3.waitrequest}, 32'h0);
      if (a < 32'd256)
         for (int i = 0; i < 4; i++) if (be[i]) mem_m[a[7:2]][8*i +: 8] = d[8*i +: 8];
      if (exp_pulse != 3'b000) val_m = d;
      @(negedge clk);
      write = 1'b0;
      check({name, " pulse"}, {29'b0, wm3, wc3, wu3}, {29'b0, exp_pulse});
      check({name, " val"}, wv3, val_m);
      check({name, " val1"}, wv1, val_m);
      if (exp_pulse != 3'b000) begin
         @(negedge clk);
         check({name, " pulse clear"}, {29'b0, wm3, wc3, wu3}, 32'h0);
      end
   endtask

   // Counts waitrequest-high cycles from the current cycle until it drops.
   task automatic wait_done(input int sel, output int waits);
      waits = 0;
      forever begin
         #1;
         if (!(sel == 3 ? bus3.waitrequest : bus1.waitrequest)) break;
         waits++;
         if (waits > 40) break;
         @(negedge clk);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int sel,
                          input bit keep, input string name);
      int w;
      @(negedge clk);
      address = a; read = 1'b1; write = 1'b0;
      wait_done(sel, w);
      check({name, " waits"}, 32'(w), 32'(sel));
      check({name, " data"}, sel == 3 ? bus3.readdata : bus1.readdata, exp);
      if (!keep) begin
         @(negedge clk);
         read = 1'b0;
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic [2:0]  exp_pulse;   // {wr_mtime, wr_mtimecmp, wr_mtime_upper}
   } vec_t;

   vec_t vecs [18];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      int          kind;
      logic [31:0] a, d;
      logic [3:0]  be;

      vecs = '{
         '{1'b1, 32'h00,            32'h0101_0101, 4'hF, 32'h0,         3'b000},
         '{1'b1, 32'h04,            32'h0202_0202, 4'hF, 32'h0,         3'b000},
         '{1'b1, 32'h10,            32'hDEAD_BEEF, 4'hF, 32'h0,         3'b000},
         '{1'b1, 32'h30,            32'h5555_AAAA, 4'hF, 32'h0,         3'b000},
         '{1'b0, 32'h10,            32'h0,         4'h0, 32'hDEAD_BEEF, 3'b000},
         '{1'b1, 32'h20,            32'hAABB_CCDD, 4'hF, 32'h0,         3'b000},
         '{1'b1, 32'h20,            32'h1122_3344, 4'h5, 32'h0,         3'b000},
         '{1'b0, 32'h20,            32'h0,         4'h0, 32'hAA22_CC44, 3'b000},
         '{1'b1, c_tbase + 32'hC,   32'h0000_1234, 4'hF, 32'h0,         3'b011},
         '{1'b1, c_tbase + 32'hC,   32'h0000_5678, 4'h3, 32'h0,         3'b000},
         '{1'b1, c_tbase + 32'h0,   32'hCAFE_0001, 4'hF, 32'h0,         3'b100},
         '{1'b1, c_tbase + 32'h4,   32'hCAFE_0002, 4'hF, 32'h0,         3'b101},
         '{1'b1, c_tbase + 32'h8,   32'hCAFE_0003, 4'hF, 32'h0,         3'b010},
         '{1'b0, 32'h8000_0000,     32'h0,         4'h0, 32'h0,         3'b000},
         '{1'b1, 32'h8000_0000,     32'hFFFF_FFFF, 4'hF, 32'h0,         3'b000},
         '{1'b0, c_tbase,           32'h0,         4'h0, 32'h0,         3'b000},
         '{1'b0, 32'h20,            32'h0,         4'h0, 32'hAA22_CC44, 3'b000},
         '{1'b0, 32'h10,            32'h0,         4'h0, 32'hDEAD_BEEF, 3'b000}
      };

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset readdata3", bus3.readdata, 32'h0);
      check("reset readdata1", bus1.readdata, 32'h0);
      check("reset waitrequest", {31'b0, bus3.waitrequest}, 32'h0);
      check("reset pulses3", {29'b0, wm3, wc3, wu3}, 32'h0);
      check("reset pulses1", {29'b0, wm1, wc1, wu1}, 32'h0);
      check("reset val3", wv3, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed table
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].is_wr)
            do_write(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp_pulse, $sformatf("vec%0d", i));
         else
            do_read(vecs[i].addr, vecs[i].exp_rd, 3, 1'b0, $sformatf("vec%0d", i));
      end

      // Back-to-back reads on the single-wait instance
      do_read(32'h0, 32'h0101_0101, 1, 1'b1, "b2b first");
      do_read(32'h4, 32'h0202_0202, 1, 1'b0, "b2b second");

      // Read and write of the same word in the same cycle
      @(negedge clk);
      address = 32'h30; read = 1'b1; write = 1'b1; writedata = 32'h0F0F_0F0F; byteenable = 4'hF;
      mem_m[12] = 32'h0F0F_0F0F;
      @(negedge clk);
      write = 1'b0;
      #1;
      check("rw same word rw1 waitrequest", {31'b0, bus1.waitrequest}, 32'h0);
      check("rw same word rw1 old data", bus1.readdata, 32'h5555_AAAA);
      @(negedge clk);
      read = 1'b0;
      do_read(32'h30, 32'h0F0F_0F0F, 3, 1'b0, "rw same word rw3 new data");

      // Reset on the second wait cycle of a READ_WAIT=3 read
      @(negedge clk);
      address = 32'h10; read = 1'b1;
      #1 check("rst-mid wait1", {31'b0, bus3.waitrequest}, 32'h1);
      @(negedge clk);
      #1 reset_n = 1'b0;
      val_m = 32'h0;
      #1;
      check("rst-mid readdata", bus3.readdata, 32'h0);
      check("rst-mid val", wv3, 32'h0);
      check("rst-mid pulses", {29'b0, wm3, wc3, wu3}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      wait_done(3, w);
      check("rst-mid waits after release", 32'(w), 32'd3);
      check("rst-mid data after release", bus3.readdata, 32'hDEAD_BEEF);
      @(negedge clk);
      read = 1'b0;

      // Randomized traffic against the model: fill RAM, then mixed ops
      for (int i = 0; i < 64; i++) do_write(32'(4 * i), $urandom, 4'hF, 3'b000, "fill");
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 6)      a = 32'(4 * $urandom_range(0, 63));
         else if (kind <= 8) a = c_tbase + 32'(4 * $urandom_range(0, 3));
         else                a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
         if ($urandom_range(0, 1) == 1) begin
            d  = $urandom;
            be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            do_write(a, d, be, model_pulse(a, be), $sformatf("rand%0d wr %h", n, a));
         end else begin
            do_read(a, model_read(a), 3, 1'b0, $sformatf("rand%0d rd %h", n, a));
         end
      end

      // Final sweep: every RAM word matches the model
      for (int i = 0; i < 64; i++)
         do_read(32'(4 * i), mem_m[i], 1, 1'b0, $sformatf("sweep %0d", i));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
